// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/stall controller: load-use interlock, branch flush, multi-cycle EX wait
// with abort timer, and data-memory stall; outputs are combinational from state and inputs.
module pipeline_ctrl #(
   parameter int MC_TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic        id_rs1_read,
   input  logic        id_rs2_read,
   input  logic [4:0]  idex_rd,
   input  logic        idex_is_load,
   input  logic        idex_reg_write,
   input  logic        ex_branch_taken,
   input  logic        ex_mc_start,
   input  logic        ex_mc_done,
   input  logic        mem_req_stall,
   output logic        pc_hold,
   output logic        ifid_hold,
   output logic        idex_hold,
   output logic        exmem_hold,
   output logic        ifid_flush,
   output logic        idex_bubble,
   output logic        exmem_bubble,
   output logic        memwb_bubble,
   output logic        mc_timeout,
   output logic [31:0] stall_cnt
);
   // state    | meaning
   // RUN      | normal flow; branch flush and load-use interlock resolved here
   // MC_WAIT  | multi-cycle EX op outstanding; front end held, abort timer running
   // MEM_WAIT | data memory stalled; pending remembers an outstanding MC op

   localparam logic [1:0] S_RUN      = 2'd0;
   localparam logic [1:0] S_MC_WAIT  = 2'd1;
   localparam logic [1:0] S_MEM_WAIT = 2'd2;

   localparam int TW = (MC_TIMEOUT > 1) ? $clog2(MC_TIMEOUT) : 1;
   localparam logic [TW-1:0] TIMER_LOAD = TW'(MC_TIMEOUT - 1);

   logic [1:0]    state, state_nxt, eff_state;
   logic          pending, pending_nxt;
   logic [TW-1:0] mc_timer, mc_timer_nxt;
   logic          timeout_set;
   logic          load_use;

   assign load_use = idex_is_load && idex_reg_write && (idex_rd != 5'd0) &&
                     ((id_rs1_read && (id_rs1 == idex_rd)) ||
                      (id_rs2_read && (id_rs2 == idex_rd)));

   // mc_timer counts down the remaining MC_WAIT cycles; zero is the abort cycle
   always_comb begin
      pc_hold      = 1'b0;
      ifid_hold    = 1'b0;
      idex_hold    = 1'b0;
      exmem_hold   = 1'b0;
      ifid_flush   = 1'b0;
      idex_bubble  = 1'b0;
      exmem_bubble = 1'b0;
      memwb_bubble = 1'b0;
      timeout_set  = 1'b0;
      state_nxt    = state;
      pending_nxt  = pending;
      mc_timer_nxt = mc_timer;
      eff_state    = (state == S_MEM_WAIT) ? (pending ? S_MC_WAIT : S_RUN) : state;

      if (rst) begin
         idex_bubble  = 1'b1;
         exmem_bubble = 1'b1;
         memwb_bubble = 1'b1;
      end else if (mem_req_stall) begin
         pc_hold      = 1'b1;
         ifid_hold    = 1'b1;
         idex_hold    = 1'b1;
         exmem_hold   = 1'b1;
         memwb_bubble = 1'b1;
         state_nxt    = S_MEM_WAIT;
         pending_nxt  = (eff_state == S_MC_WAIT);
      end else if (eff_state == S_MC_WAIT) begin
         pending_nxt = 1'b0;
         state_nxt   = S_MC_WAIT;
         if (ex_mc_done) begin
            state_nxt = S_RUN;
         end else if (mc_timer == '0) begin
            timeout_set  = 1'b1;
            exmem_bubble = 1'b1;
            state_nxt    = S_RUN;
         end else begin
            pc_hold      = 1'b1;
            ifid_hold    = 1'b1;
            idex_hold    = 1'b1;
            exmem_bubble = 1'b1;
            mc_timer_nxt = mc_timer - TW'(1);
         end
      end else begin
         pending_nxt = 1'b0;
         state_nxt   = S_RUN;
         if (ex_mc_start && !ex_mc_done) begin
            pc_hold      = 1'b1;
            ifid_hold    = 1'b1;
            idex_hold    = 1'b1;
            exmem_bubble = 1'b1;
            state_nxt    = S_MC_WAIT;
            mc_timer_nxt = TIMER_LOAD;
         end else if (ex_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
         end else if (load_use) begin
            pc_hold     = 1'b1;
            ifid_hold   = 1'b1;
            idex_bubble = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_RUN;
         pending    <= 1'b0;
         mc_timer   <= '0;
         mc_timeout <= 1'b0;
         stall_cnt  <= 32'd0;
      end else begin
         state    <= state_nxt;
         pending  <= pending_nxt;
         mc_timer <= mc_timer_nxt;
         if (timeout_set)
            mc_timeout <= 1'b1;
         if (pc_hold)
            stall_cnt <= stall_cnt + 32'd1;
      end
   end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: two instances (default and short timeout) driven by shared
// directed and random stimulus, checked against a per-instance behavioural model.
module tb_pipeline_ctrl;
   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  id_rs1, id_rs2, idex_rd;
   logic        id_rs1_read, id_rs2_read, idex_is_load, idex_reg_write;
   logic        ex_branch_taken, ex_mc_start, ex_mc_done, mem_req_stall;

   logic pc_hold_a, ifid_hold_a, idex_hold_a, exmem_hold_a;
   logic ifid_flush_a, idex_bubble_a, exmem_bubble_a, memwb_bubble_a, mc_timeout_a;
   logic [31:0] stall_cnt_a;
   logic pc_hold_b, ifid_hold_b, idex_hold_b, exmem_hold_b;
   logic ifid_flush_b, idex_bubble_b, exmem_bubble_b, memwb_bubble_b, mc_timeout_b;
   logic [31:0] stall_cnt_b;
   logic [7:0]  out_a, out_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pipeline_ctrl u_a (
      .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_read(id_rs1_read), .id_rs2_read(id_rs2_read), .idex_rd(idex_rd),
      .idex_is_load(idex_is_load), .idex_reg_write(idex_reg_write),
      .ex_branch_taken(ex_branch_taken), .ex_mc_start(ex_mc_start), .ex_mc_done(ex_mc_done),
      .mem_req_stall(mem_req_stall), .pc_hold(pc_hold_a), .ifid_hold(ifid_hold_a),
      .idex_hold(idex_hold_a), .exmem_hold(exmem_hold_a), .ifid_flush(ifid_flush_a),
      .idex_bubble(idex_bubble_a), .exmem_bubble(exmem_bubble_a), .memwb_bubble(memwb_bubble_a),
      .mc_timeout(mc_timeout_a), .stall_cnt(stall_cnt_a)
   );

   pipeline_ctrl #(.MC_TIMEOUT(4)) u_b (
      .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_read(id_rs1_read), .id_rs2_read(id_rs2_read), .idex_rd(idex_rd),
      .idex_is_load(idex_is_load), .idex_reg_write(idex_reg_write),
      .ex_branch_taken(ex_branch_taken), .ex_mc_start(ex_mc_start), .ex_mc_done(ex_mc_done),
      .mem_req_stall(mem_req_stall), .pc_hold(pc_hold_b), .ifid_hold(ifid_hold_b),
      .idex_hold(idex_hold_b), .exmem_hold(exmem_hold_b), .ifid_flush(ifid_flush_b),
      .idex_bubble(idex_bubble_b), .exmem_bubble(exmem_bubble_b), .memwb_bubble(memwb_bubble_b),
      .mc_timeout(mc_timeout_b), .stall_cnt(stall_cnt_b)
   );

   // {pc_hold, ifid_hold, idex_hold, exmem_hold, ifid_flush, idex_bubble, exmem_bubble, memwb_bubble}
   assign out_a = {pc_hold_a, ifid_hold_a, idex_hold_a, exmem_hold_a,
                   ifid_flush_a, idex_bubble_a, exmem_bubble_a, memwb_bubble_a};
   assign out_b = {pc_hold_b, ifid_hold_b, idex_hold_b, exmem_hold_b,
                   ifid_flush_b, idex_bubble_b, exmem_bubble_b, memwb_bubble_b};

   localparam logic [7:0] O_IDLE  = 8'b0000_0000;
   localparam logic [7:0] O_RESET = 8'b0000_0111;
   localparam logic [7:0] O_LU    = 8'b1100_0100;
   localparam logic [7:0] O_BR    = 8'b0000_1100;
   localparam logic [7:0] O_MC    = 8'b1110_0010;
   localparam logic [7:0] O_ABORT = 8'b0000_0010;
   localparam logic [7:0] O_MEM   = 8'b1111_0001;

   // Model view: an outstanding multi-cycle op, cycles it has waited, sticky abort, stall count.
   // A memory stall freezes everything, so the model needs no separate memory-wait state.
   int          m_limit [2] = '{64, 4};
   bit          m_busy  [2];
   int          m_wait  [2];
   bit          m_to    [2];
   logic [31:0] m_cnt   [2];
   bit          n_busy  [2];
   int          n_wait  [2];
   bit          n_to    [2];
   logic [31:0] n_cnt   [2];
   logic [7:0]  m_out   [2];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h expected=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_eval(input int i);
      logic [7:0] o;
      bit hazard;
      hazard = idex_is_load && idex_reg_write && idex_rd != 0 &&
               ((id_rs1_read && id_rs1 == idex_rd) || (id_rs2_read && id_rs2 == idex_rd));
      o = O_IDLE;
      n_busy[i] = m_busy[i];
      n_wait[i] = m_wait[i];
      n_to[i]   = m_to[i];
      if (rst) begin
         o = O_RESET;
      end else if (mem_req_stall) begin
         o = O_MEM;
      end else if (m_busy[i]) begin
         if (ex_mc_done) begin
            n_busy[i] = 0;
         end else if (m_wait[i] == m_limit[i] - 1) begin
            o = O_ABORT;
            n_busy[i] = 0;
            n_to[i] = 1;
         end else begin
            o = O_MC;
            n_wait[i] = m_wait[i] + 1;
         end
      end else if (ex_mc_start && !ex_mc_done) begin
         o = O_MC;
         n_busy[i] = 1;
         n_wait[i] = 0;
      end else if (ex_branch_taken) begin
         o = O_BR;
      end else if (hazard) begin
         o = O_LU;
      end
      n_cnt[i] = m_cnt[i] + (o[7] ? 32'd1 : 32'd0);
      if (rst) begin
         n_busy[i] = 0;
         n_wait[i] = 0;
         n_to[i]   = 0;
         n_cnt[i]  = 0;
      end
      m_out[i] = o;
   endtask

   // Inputs are set just after a falling edge; compare, then advance one clock.
   task automatic cycle();
      #1;
      model_eval(0);
      model_eval(1);
      check("out_a", {24'd0, out_a}, {24'd0, m_out[0]});
      check("out_b", {24'd0, out_b}, {24'd0, m_out[1]});
      check("mc_timeout_a", {31'd0, mc_timeout_a}, {31'd0, m_to[0]});
      check("mc_timeout_b", {31'd0, mc_timeout_b}, {31'd0, m_to[1]});
      check("stall_cnt_a", stall_cnt_a, m_cnt[0]);
      check("stall_cnt_b", stall_cnt_b, m_cnt[1]);
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         m_busy[i] = n_busy[i];
         m_wait[i] = n_wait[i];
         m_to[i]   = n_to[i];
         m_cnt[i]  = n_cnt[i];
      end
      @(negedge clk);
   endtask

   task automatic idle();
      rst = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_read = 0; id_rs2_read = 0;
      idex_rd = 0; idex_is_load = 0; idex_reg_write = 0; ex_branch_taken = 0;
      ex_mc_start = 0; ex_mc_done = 0; mem_req_stall = 0;
   endtask

   task automatic do_reset();
      idle();
      rst = 1;
      #1;
      check("rst_out_a", {24'd0, out_a}, {24'd0, O_RESET});
      check("rst_out_b", {24'd0, out_b}, {24'd0, O_RESET});
      cycle();
      rst = 0;
   endtask

   task automatic set_load_use();
      idex_is_load = 1; idex_reg_write = 1; idex_rd = 5'd1; id_rs1 = 5'd1; id_rs1_read = 1;
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         m_busy[i] = 0; m_wait[i] = 0; m_to[i] = 0; m_cnt[i] = 0;
      end
      idle();
      rst = 1;
      @(negedge clk);
      do_reset();
      #1;
      check("reset_cnt", stall_cnt_a, 32'd0);
      check("reset_to", {31'd0, mc_timeout_a}, 32'd0);
      check("run_idle", {24'd0, out_a}, {24'd0, O_IDLE});

      // load-use, then the same against x0
      set_load_use();
      #1 check("lu_out", {24'd0, out_a}, {24'd0, O_LU});
      cycle();
      check("lu_cnt", stall_cnt_a, 32'd1);
      idle();
      set_load_use();
      idex_rd = 0; id_rs1 = 0;
      #1 check("lu_x0", {24'd0, out_a}, {24'd0, O_IDLE});
      cycle();

      // branch wins over load-use
      set_load_use();
      ex_branch_taken = 1;
      #1 check("br_lu", {24'd0, out_a}, {24'd0, O_BR});
      cycle();

      // divide done after 5 cycles on the long-timeout instance
      do_reset();
      ex_mc_start = 1;
      #1 check("div_start", {24'd0, out_a}, {24'd0, O_MC});
      cycle();
      ex_mc_start = 0;
      for (int k = 0; k < 4; k++) begin
         #1 check("div_wait", {24'd0, out_a}, {24'd0, O_MC});
         cycle();
      end
      ex_mc_done = 1;
      #1 check("div_done", {24'd0, out_a}, {24'd0, O_IDLE});
      cycle();
      ex_mc_done = 0;
      check("div_cnt", stall_cnt_a, 32'd5);

      // timeout on the MC_TIMEOUT=4 instance
      do_reset();
      ex_mc_start = 1;
      cycle();
      ex_mc_start = 0;
      for (int k = 0; k < 3; k++) cycle();
      #1 check("to_abort_out", {24'd0, out_b}, {24'd0, O_ABORT});
      check("to_before", {31'd0, mc_timeout_b}, 32'd0);
      cycle();
      check("to_set", {31'd0, mc_timeout_b}, 32'd1);
      check("to_run", {24'd0, out_b}, {24'd0, O_IDLE});
      for (int k = 0; k < 3; k++) cycle();
      check("to_sticky", {31'd0, mc_timeout_b}, 32'd1);
      check("to_cnt", stall_cnt_b, 32'd4);

      // memory stall in MC_WAIT freezes the timer
      do_reset();
      ex_mc_start = 1;
      cycle();
      ex_mc_start = 0;
      cycle();
      cycle();
      mem_req_stall = 1;
      for (int k = 0; k < 3; k++) begin
         #1 check("mem_out", {24'd0, out_a}, {24'd0, O_MEM});
         cycle();
      end
      mem_req_stall = 0;
      #1 check("mem_ret_a", {24'd0, out_a}, {24'd0, O_MC});
      check("mem_ret_b", {24'd0, out_b}, {24'd0, O_MC});
      cycle();
      #1 check("mem_frozen_b", {24'd0, out_b}, {24'd0, O_ABORT});
      cycle();
      ex_mc_done = 1;
      cycle();
      ex_mc_done = 0;

      // reset in the middle of MC_WAIT
      ex_mc_start = 1;
      cycle();
      ex_mc_start = 0;
      cycle();
      do_reset();
      #1;
      check("rst_mid_cnt", stall_cnt_a, 32'd0);
      check("rst_mid_to", {31'd0, mc_timeout_b}, 32'd0);
      check("rst_mid_out", {24'd0, out_a}, {24'd0, O_IDLE});

      // random traffic
      for (int n = 0; n < 3000; n++) begin
         rst             = ($urandom_range(0, 199) == 0);
         mem_req_stall   = ($urandom_range(0, 5) == 0);
         ex_mc_start     = ($urandom_range(0, 7) == 0);
         ex_mc_done      = ($urandom_range(0, 4) == 0);
         ex_branch_taken = ($urandom_range(0, 5) == 0);
         idex_is_load    = $urandom_range(0, 1) == 1;
         idex_reg_write  = $urandom_range(0, 3) != 0;
         idex_rd         = 5'($urandom_range(0, 3));
         id_rs1          = 5'($urandom_range(0, 3));
         id_rs2          = 5'($urandom_range(0, 3));
         id_rs1_read     = $urandom_range(0, 1) == 1;
         id_rs2_read     = $urandom_range(0, 1) == 1;
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
